// File: rtl/fpdiv_ctrl.sv
// Control sequencer for the Goldschmidt divider datapath: stages the operand pair,
// steps the mux selects and register enables through the rounds, and holds the quotient.
module fpdiv_ctrl #(
  parameter int ITERS = 3,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   a_in,
  input  logic [31:0]   b_in,
  input  logic          rm_in,
  input  logic          flush,
  output logic [31:0]   dp_num,
  output logic [31:0]   dp_denom,
  output logic          dp_rm,
  output logic          en_a,
  output logic          en_b,
  output logic          en_rem,
  output logic [1:0]    sel_mux3,
  output logic [1:0]    sel_mux4,
  input  logic [31:0]   final_ans,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          busy,
  output logic [CW-1:0] iter_cnt,
  output logic [2:0]    dbg_state
);

  // Handshakes: a transfer occurs on a rising edge where valid and ready are both high;
  // out_valid/out_data stay put until taken, and ready may depend on the partner's ready.
  typedef enum logic [2:0] {
    S_IDLE, S_INIT_N, S_INIT_D, S_IT_N, S_IT_D, S_REM, S_CAPT, S_DONE
  } state_t;

  localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_dp_num;
  logic [31:0]   r_dp_denom;
  logic          r_dp_rm;
  logic [31:0]   r_out_data;
  logic [CW-1:0] r_iter_cnt;
  logic          w_take;

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    en_a      = 1'b0;
    en_b      = 1'b0;
    en_rem    = 1'b0;
    sel_mux3  = 2'd0;
    sel_mux4  = 2'd0;
    case (r_state)
      S_IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) w_next = S_INIT_N;
      end
      S_INIT_N: begin
        en_a   = 1'b1;
        w_next = S_INIT_D;
      end
      S_INIT_D: begin
        sel_mux4 = 2'd1;
        en_b     = 1'b1;
        w_next   = S_IT_N;
      end
      S_IT_N: begin
        sel_mux3 = 2'd1;
        sel_mux4 = 2'd2;
        en_a     = 1'b1;
        w_next   = S_IT_D;
      end
      S_IT_D: begin
        sel_mux3 = 2'd1;
        sel_mux4 = 2'd3;
        en_b     = 1'b1;
        w_next   = (r_iter_cnt == LAST_ITER) ? S_REM : S_IT_N;
      end
      S_REM: begin
        sel_mux3 = 2'd2;
        sel_mux4 = 2'd2;
        en_rem   = 1'b1;
        w_next   = S_CAPT;
      end
      S_CAPT: w_next = S_DONE;
      S_DONE: begin
        busy      = 1'b0;
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_next = in_valid ? S_INIT_N : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // A flush cycle never accepts operands, so ready drops with it.
    if (flush) begin
      w_next   = S_IDLE;
      in_ready = 1'b0;
    end
  end

  assign w_take = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_dp_num   <= 32'd0;
      r_dp_denom <= 32'd0;
      r_dp_rm    <= 1'b0;
      r_out_data <= 32'd0;
      r_iter_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_dp_num   <= a_in;
        r_dp_denom <= b_in;
        r_dp_rm    <= rm_in;
      end
      if (flush || w_take)
        r_iter_cnt <= '0;
      else if (r_state == S_IT_D)
        r_iter_cnt <= r_iter_cnt + CW'(1);
      if (r_state == S_CAPT && !flush)
        r_out_data <= final_ans;
    end
  end

  assign dp_num    = r_dp_num;
  assign dp_denom  = r_dp_denom;
  assign dp_rm     = r_dp_rm;
  assign out_data  = r_out_data;
  assign iter_cnt  = r_iter_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Self-checking bench for fpdiv_ctrl: a cycle-indexed model of the control sequence
// plus a queue of captured datapath results checked against out_data.
module tb_fpdiv_ctrl;
  localparam int ITERS  = 3;
  localparam int CW     = 3;
  localparam int LAT    = 5 + 2 * ITERS;
  localparam int CAPT_K = 4 + 2 * ITERS;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          rm_in = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [31:0]   a_in = 32'd0;
  logic [31:0]   b_in = 32'd0;
  logic [31:0]   final_ans = 32'd0;
  logic          in_ready, dp_rm, en_a, en_b, en_rem, out_valid, busy;
  logic [31:0]   dp_num, dp_denom, out_data;
  logic [1:0]    sel_mux3, sel_mux4;
  logic [CW-1:0] iter_cnt;
  logic [2:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  fpdiv_ctrl #(.ITERS(ITERS), .CW(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .rm_in(rm_in), .flush(flush),
    .dp_num(dp_num), .dp_denom(dp_denom), .dp_rm(dp_rm),
    .en_a(en_a), .en_b(en_b), .en_rem(en_rem),
    .sel_mux3(sel_mux3), .sel_mux4(sel_mux4), .final_ans(final_ans),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .iter_cnt(iter_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / datapath stand-in ----------------
  always #5 clk = ~clk;

  // The datapath result wanders every cycle, so a capture on the wrong cycle shows up.
  always @(posedge clk) begin
    #2;
    final_ans = $urandom;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Expected {sel_mux3, sel_mux4, en_a, en_b, en_rem, busy, out_valid, iter_cnt} in cycle k
  // after the handshake edge: INIT_N, INIT_D, ITERS x (IT_N, IT_D), REM, CAPT, then DONE.
  function automatic logic [8+CW:0] exp_ctrl(input int k);
    logic [1:0] s3, s4;
    logic [2:0] en;
    logic       bsy, ov;
    int         cnt;
    s3 = 2'd0; s4 = 2'd0; en = 3'b000; bsy = 1'b1; ov = 1'b0; cnt = 0;
    if (k == 1) begin
      en = 3'b100;
    end else if (k == 2) begin
      s4 = 2'd1; en = 3'b010;
    end else if (k <= 2 + 2 * ITERS) begin
      cnt = (k - 3) / 2;
      s3  = 2'd1;
      if ((k - 3) % 2 == 0) begin s4 = 2'd2; en = 3'b100; end
      else begin s4 = 2'd3; en = 3'b010; end
    end else if (k == 3 + 2 * ITERS) begin
      s3 = 2'd2; s4 = 2'd2; en = 3'b001; cnt = ITERS;
    end else if (k == 4 + 2 * ITERS) begin
      cnt = ITERS;
    end else begin
      bsy = 1'b0; ov = 1'b1; cnt = ITERS;
    end
    return {s3, s4, en, bsy, ov, cnt[CW-1:0]};
  endfunction

  function automatic logic [8+CW:0] obs_ctrl();
    return {sel_mux3, sel_mux4, en_a, en_b, en_rem, busy, out_valid, iter_cnt};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge of cycle 1 after the handshake edge.
  task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic rm);
    bit ok;
    ok = 0;
    in_valid = 1'b1; a_in = a; b_in = b; rm_in = rm;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (in_ready === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%b exp=1", in_ready);
    end
  endtask

  // Waits for out_valid, queueing the datapath value present in the capture cycle.
  task automatic wait_result(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      if (n > 1) @(negedge clk);
      if (n == CAPT_K) exp_q.push_back(final_ans);
      if (out_valid === 1'b1) begin lat = n; break; end
    end
  endtask

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() > 0) return exp_q.pop_front();
    return 32'hxxxxxxxx;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (obs_ctrl() !== '0) begin
      errors++; $display("FAIL reset_ctrl got=%h exp=%h", obs_ctrl(), 0);
    end
    checks++;
    if ({in_ready, dp_rm, dp_num, dp_denom, out_data} !== {1'b1, 1'b0, 96'd0}) begin
      errors++;
      $display("FAIL reset_regs in_ready=%b dp_rm=%b num=%h den=%h out=%h exp 1/0/0/0/0",
               in_ready, dp_rm, dp_num, dp_denom, out_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_sequence();
    logic [31:0] exp;
    out_ready = 1'b1;
    offer(32'h3FC00000, 32'h3F800000, 1'b1);
    for (int k = 1; k <= LAT; k++) begin
      if (k > 1) @(negedge clk);
      if (k == CAPT_K) exp_q.push_back(final_ans);
      checks++;
      if (obs_ctrl() !== exp_ctrl(k)) begin
        errors++; $display("FAIL seq_k%0d got=%h exp=%h", k, obs_ctrl(), exp_ctrl(k));
      end
      checks++;
      if (in_ready !== (k == LAT)) begin
        errors++; $display("FAIL seq_ready_k%0d got=%b exp=%b", k, in_ready, k == LAT);
      end
    end
    exp = pop_exp();
    checks++;
    if ({out_data, dp_num, dp_denom, dp_rm} !== {exp, 32'h3FC00000, 32'h3F800000, 1'b1}) begin
      errors++;
      $display("FAIL seq_data out=%h exp=%h num=%h den=%h rm=%b", out_data, exp, dp_num, dp_denom, dp_rm);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      errors++; $display("FAIL seq_drain got=%b exp=001", {out_valid, busy, in_ready});
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    int lat;
    out_ready = 1'b0;
    offer($urandom, $urandom, 1'b0);
    wait_result(lat);
    exp = pop_exp();
    checks++;
    if (lat !== LAT) begin
      errors++; $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, exp}) begin
        errors++;
        $display("FAIL bp_hold_%0d valid=%b ready=%b data=%h exp 1/0/%h", i, out_valid, in_ready, out_data, exp);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    int lat;
    out_ready = 1'b0;
    offer(32'h3FC00000, 32'h3F800000, 1'b1);
    wait_result(lat);
    exp = pop_exp();
    checks++;
    if ({lat == LAT, out_data} !== {1'b1, exp}) begin
      errors++; $display("FAIL b2b_first lat=%0d data=%h exp %0d/%h", lat, out_data, LAT, exp);
    end
    out_ready = 1'b1;
    offer(32'h40400000, 32'h40000000, 1'b1);
    for (int k = 1; k <= LAT; k++) begin
      if (k > 1) @(negedge clk);
      if (k == CAPT_K) exp_q.push_back(final_ans);
      checks++;
      if (obs_ctrl() !== exp_ctrl(k)) begin
        errors++; $display("FAIL b2b_k%0d got=%h exp=%h", k, obs_ctrl(), exp_ctrl(k));
      end
    end
    exp = pop_exp();
    checks++;
    if ({out_data, dp_num, dp_denom} !== {exp, 32'h40400000, 32'h40000000}) begin
      errors++; $display("FAIL b2b_second out=%h exp=%h num=%h den=%h", out_data, exp, dp_num, dp_denom);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    logic [31:0] a, exp;
    int lat, pulses;
    a = $urandom;
    out_ready = 1'b1;
    offer(a, 32'h3F800000, 1'b0);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, en_a, en_b, en_rem, iter_cnt, dp_num} !== {5'b01000, {CW{1'b0}}, a}) begin
      errors++;
      $display("FAIL flush_idle busy=%b rdy=%b en=%b%b%b cnt=%0d num=%h exp num=%h", busy, in_ready,
               en_a, en_b, en_rem, iter_cnt, dp_num, a);
    end
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL flush_no_result got=%0d exp=0", pulses);
    end
    offer(32'h40400000, 32'h40000000, 1'b1);
    wait_result(lat);
    exp = pop_exp();
    checks++;
    if ({lat == LAT, out_data} !== {1'b1, exp}) begin
      errors++; $display("FAIL flush_after lat=%0d data=%h exp %0d/%h", lat, out_data, LAT, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_operand_hold();
    logic [31:0] a, b, exp;
    a = $urandom; b = $urandom;
    out_ready = 1'b0;
    offer(a, b, 1'b1);
    for (int n = 1; n <= LAT + 3; n++) begin
      if (n > 1) @(negedge clk);
      if (n == CAPT_K) exp_q.push_back(final_ans);
      checks++;
      if ({dp_num, dp_denom} !== {a, b}) begin
        errors++; $display("FAIL hold_n%0d num=%h den=%h exp %h/%h", n, dp_num, dp_denom, a, b);
      end
      a_in = $urandom; b_in = $urandom; in_valid = 1'b1;
    end
    in_valid = 1'b0;
    exp = pop_exp();
    checks++;
    if ({out_valid, out_data} !== {1'b1, exp}) begin
      errors++; $display("FAIL hold_result valid=%b data=%h exp 1/%h", out_valid, out_data, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++; $display("FAIL hold_drain got=%b exp=00", {busy, out_valid});
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, exp;
    logic rm;
    int lat, stall;
    out_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      a = $urandom; b = $urandom; rm = 1'($urandom_range(0, 1));
      offer(a, b, rm);
      out_ready = 1'b0;
      wait_result(lat);
      exp = pop_exp();
      checks++;
      if ({lat == LAT, out_data, dp_num, dp_denom, dp_rm} !== {1'b1, exp, a, b, rm}) begin
        errors++;
        $display("FAIL rand_%0d lat=%0d data=%h exp=%h num=%h den=%h rm=%b", t, lat, out_data, exp,
                 dp_num, dp_denom, dp_rm);
      end
      stall = $urandom_range(0, 4);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        checks++;
        if ({out_valid, out_data} !== {1'b1, exp}) begin
          errors++; $display("FAIL rand_stall_%0d valid=%b data=%h exp=%h", t, out_valid, out_data, exp);
        end
      end
      out_ready = 1'b1;
      if ($urandom_range(0, 1) == 0) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL rand_release_%0d got=%b exp=0", t, out_valid);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int pulses;
    out_ready = 1'b0;
    offer($urandom, $urandom, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (en_b !== 1'b1) begin
      errors++; $display("FAIL areset_in_it_d en_b=%b exp=1", en_b);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({obs_ctrl(), in_ready, dp_rm, dp_num, dp_denom, out_data} !== {{(9+CW){1'b0}}, 1'b1, 1'b0, 96'd0}) begin
      errors++;
      $display("FAIL areset_values ctrl=%h rdy=%b num=%h den=%h out=%h exp 0/1/0/0/0", obs_ctrl(),
               in_ready, dp_num, dp_denom, out_data);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if ({out_valid, busy, in_ready} !== 3'b001) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL areset_quiet got=%0d bad cycles exp=0", pulses);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_sequence();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_operand_hold();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
